// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and sequencer for a shared tri-state bus.
// Grants ownership to one master at a time, drives the sel code that enables
// exactly one bidir_unit driver, inserts one dead cycle between owners, and
// revokes a grant held for TIMEOUT consecutive cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   req      in   [N_MASTERS] level-sensitive bus requests
//   done     in   [N_MASTERS] release strobes, honoured only from the owner
//   grant    out  [N_MASTERS] one-hot ownership, zero when bus is free
//   sel      out  [SEL_W] owner index+1, or 0 (bus Z)
//   busy     out  high while any grant is asserted
//   timeout  out  one-cycle pulse when the watchdog revokes ownership
//   owner_id out  [SEL_W] sel code of the most recent owner, held after release
module bus_arbiter #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req,
  input  logic [N_MASTERS-1:0] done,
  output logic [N_MASTERS-1:0] grant,
  output logic [SEL_W-1:0]     sel,
  output logic                 busy,
  output logic                 timeout,
  output logic [SEL_W-1:0]     owner_id
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_t;

  state_t                 state, state_n;
  logic [N_MASTERS-1:0]   grant_n;
  logic [SEL_W-1:0]       sel_n;
  logic                   busy_n;
  logic                   timeout_n;
  logic [SEL_W-1:0]       owner_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [SEL_W-1:0]       last, last_n;

  // Round-robin pick: first requester scanning cyclically from last+1.
  logic                   pick_found;
  logic [SEL_W-1:0]       pick_idx;
  int unsigned            cand;
  logic [SEL_W-1:0]       cidx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cidx       = '0;
    for (int unsigned k = 1; k <= N_MASTERS; k++) begin
      cand = (32'(last) + k) % N_MASTERS;
      cidx = cand[SEL_W-1:0];
      if (!pick_found && req[cidx]) begin
        pick_found = 1'b1;
        pick_idx   = cidx;
      end
    end
  end

  // Release causes, qualified by the current grant so non-owner strobes
  // and requests have no effect.
  logic rel_done, rel_drop, rel_to;

  always_comb begin
    rel_done  = |(done & grant);
    rel_drop  = ~|(req & grant);
    rel_to    = (cnt == CNT_W'(TIMEOUT - 1));

    state_n   = state;
    grant_n   = grant;
    sel_n     = sel;
    busy_n    = busy;
    timeout_n = 1'b0;
    owner_n   = owner_id;
    cnt_n     = cnt;
    last_n    = last;

    case (state)
      IDLE, GAP: begin
        grant_n = '0;
        sel_n   = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
        if (pick_found) begin
          state_n           = OWN;
          grant_n[pick_idx] = 1'b1;
          sel_n             = pick_idx + SEL_W'(1);
          busy_n            = 1'b1;
          owner_n           = pick_idx + SEL_W'(1);
          cnt_n             = '0;
        end
      end
      OWN: begin
        if (rel_done || rel_drop || rel_to) begin
          state_n   = GAP;
          grant_n   = '0;
          sel_n     = '0;
          busy_n    = 1'b0;
          last_n    = sel - SEL_W'(1);
          // Graceful release on the final cycle wins over the watchdog.
          timeout_n = rel_to && !rel_done && !rel_drop;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
        sel_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      owner_id <= '0;
      cnt      <= '0;
      last     <= SEL_W'(N_MASTERS - 1);
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      sel      <= sel_n;
      busy     <= busy_n;
      timeout  <= timeout_n;
      owner_id <= owner_n;
      cnt      <= cnt_n;
      last     <= last_n;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] done;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;
  logic [1:0] owner_id;

  int unsigned n_tests;
  int unsigned n_fail;

  bus_arbiter #(
    .N_MASTERS(3),
    .SEL_W    (2),
    .TIMEOUT  (16),
    .CNT_W    (5)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout),
    .owner_id(owner_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic negedge_wait();
    @(negedge clk);
  endtask

  int unsigned rr_sel [13] = '{1, 1, 1, 0, 2, 2, 2, 0, 3, 3, 3, 0, 1};
  int unsigned exp_g;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst  = 1'b1;
    req  = 3'b111;
    done = 3'b000;

    // Reset holds all outputs low even with every master requesting.
    for (int i = 0; i < 2; i++) begin
      negedge_wait();
      check("rst_grant", grant, 0);
      check("rst_sel", sel, 0);
      check("rst_busy", busy, 0);
      check("rst_timeout", timeout, 0);
      check("rst_owner", owner_id, 0);
    end
    rst = 1'b0;
    negedge_wait();
    check("first_grant", grant, 3'b001);
    check("first_sel", sel, 1);
    check("first_busy", busy, 1);
    check("first_owner", owner_id, 1);

    // Drain to IDLE.
    req = 3'b000;
    negedge_wait();
    negedge_wait();

    // Single request held for five edges.
    req = 3'b010;
    for (int i = 0; i < 5; i++) begin
      negedge_wait();
      check("single_grant", grant, 3'b010);
      check("single_sel", sel, 2);
    end
    req = 3'b000;
    negedge_wait();
    check("single_gap_sel", sel, 0);
    check("single_gap_busy", busy, 0);
    check("single_gap_to", timeout, 0);
    check("single_owner_hold", owner_id, 2);
    negedge_wait();
    check("single_idle_sel", sel, 0);

    // Round-robin from a fresh pointer; each owner releases on its 3rd cycle.
    rst = 1'b1;
    negedge_wait();
    rst = 1'b0;
    req = 3'b111;
    for (int c = 0; c < 13; c++) begin
      negedge_wait();
      check("rr_sel", sel, rr_sel[c]);
      exp_g = (rr_sel[c] == 0) ? 0 : (1 << (rr_sel[c] - 1));
      check("rr_grant", grant, exp_g);
      check("rr_busy", busy, (rr_sel[c] != 0) ? 1 : 0);
      done = (rr_sel[c] != 0 && (c % 4) == 2) ? 3'(exp_g) : 3'b000;
    end

    // Master 0 owns (1 cycle so far). Foreign done must not release or
    // restart the hold count: watchdog still fires after 16 owned cycles.
    req  = 3'b001;
    done = 3'b100;
    for (int i = 2; i <= 16; i++) begin
      negedge_wait();
      check("foreign_sel", sel, 1);
      check("to_hold_to", timeout, 0);
      if (i == 5) done = 3'b000;
    end
    negedge_wait();
    check("to_pulse", timeout, 1);
    check("to_sel", sel, 0);
    check("to_grant", grant, 0);
    negedge_wait();
    check("to_pulse_end", timeout, 0);
    check("regrant_sel", sel, 1);
    check("regrant_owner", owner_id, 1);

    // done on the final permitted cycle gives a graceful release.
    for (int i = 2; i <= 16; i++) begin
      negedge_wait();
      check("final_hold_sel", sel, 1);
      if (i == 16) done = 3'b001;
    end
    negedge_wait();
    done = 3'b000;
    check("final_done_sel", sel, 0);
    check("final_done_to", timeout, 0);

    // Hand over to master 2, then reset mid-ownership.
    negedge_wait();
    check("rereq_sel", sel, 1);
    req = 3'b100;
    negedge_wait();
    check("hand_gap_sel", sel, 0);
    negedge_wait();
    check("m2_sel", sel, 3);
    check("m2_grant", grant, 3'b100);
    #2 rst = 1'b1;
    #1;
    check("async_sel", sel, 0);
    check("async_grant", grant, 0);
    check("async_busy", busy, 0);
    negedge_wait();
    rst = 1'b0;
    req = 3'b101;
    negedge_wait();
    check("post_rst_grant", grant, 3'b001);
    check("post_rst_sel", sel, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
